// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmit and receive engines.
// Both FSMs use the same 3-bit state encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [15:0] DEFAULT_CLKS_PER_BIT = 16'd100;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// Receive engine: synchronizes the serial pin, checks the start bit at
// mid-bit, then samples data and stop bits at mid-bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);

  localparam logic [15:0] LAST_COUNT = CLKS_PER_BIT - 16'd1;
  localparam logic [15:0] HALF_COUNT = (CLKS_PER_BIT - 16'd1) >> 1;

  uart_state_e r_state;
  logic [15:0] r_clkCount;
  logic [2:0]  r_bitIdx;
  logic [7:0]  r_rxShift;
  logic        r_rxMeta;
  logic        r_rxSync;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= i_Rx_Serial;
      r_rxSync <= r_rxMeta;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_state    <= IDLE;
      r_clkCount <= 16'd0;
      r_bitIdx   <= 3'd0;
      r_rxShift  <= 8'd0;
      o_Rx_DV    <= 1'b0;
      o_Rx_Byte  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          o_Rx_DV    <= 1'b0;
          r_clkCount <= 16'd0;
          r_bitIdx   <= 3'd0;
          if (!r_rxSync) begin
            r_state <= START;
          end
        end
        START: begin
          // A start bit that has gone high again by mid-bit is a glitch.
          if (r_clkCount == HALF_COUNT) begin
            r_clkCount <= 16'd0;
            r_state    <= r_rxSync ? IDLE : DATA;
          end else begin
            r_clkCount <= r_clkCount + 16'd1;
          end
        end
        DATA: begin
          if (r_clkCount < LAST_COUNT) begin
            r_clkCount <= r_clkCount + 16'd1;
          end else begin
            r_clkCount          <= 16'd0;
            r_rxShift[r_bitIdx] <= r_rxSync;
            if (r_bitIdx < LAST_BIT) begin
              r_bitIdx <= r_bitIdx + 3'd1;
            end else begin
              r_bitIdx <= 3'd0;
              r_state  <= STOP;
            end
          end
        end
        STOP: begin
          if (r_clkCount < LAST_COUNT) begin
            r_clkCount <= r_clkCount + 16'd1;
          end else begin
            r_clkCount <= 16'd0;
            r_state    <= CLEANUP;
            if (r_rxSync) begin
              o_Rx_Byte <= r_rxShift;
              o_Rx_DV   <= 1'b1;
            end
          end
        end
        CLEANUP: begin
          o_Rx_DV <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// Transmit engine: frames one byte as start, 8 data bits LSB first, stop.
// All outputs are registered straight out of the FSM.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam logic [15:0] LAST_COUNT = CLKS_PER_BIT - 16'd1;

  uart_state_e r_state;
  logic [15:0] r_clkCount;
  logic [2:0]  r_bitIdx;
  logic [7:0]  r_txShift;

  // The next line level is loaded at the same edge as the state change,
  // so each bit is held for exactly CLKS_PER_BIT cycles.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_state     <= IDLE;
      r_clkCount  <= 16'd0;
      r_bitIdx    <= 3'd0;
      r_txShift   <= 8'd0;
      o_Tx_Active <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Done   <= 1'b0;
          r_clkCount  <= 16'd0;
          r_bitIdx    <= 3'd0;
          if (i_Tx_DV) begin
            r_txShift   <= i_Tx_Byte;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
            r_state     <= START;
          end
        end
        START: begin
          if (r_clkCount < LAST_COUNT) begin
            r_clkCount <= r_clkCount + 16'd1;
          end else begin
            r_clkCount  <= 16'd0;
            o_Tx_Serial <= r_txShift[0];
            r_txShift   <= {1'b0, r_txShift[7:1]};
            r_state     <= DATA;
          end
        end
        DATA: begin
          if (r_clkCount < LAST_COUNT) begin
            r_clkCount <= r_clkCount + 16'd1;
          end else begin
            r_clkCount <= 16'd0;
            if (r_bitIdx < LAST_BIT) begin
              r_bitIdx    <= r_bitIdx + 3'd1;
              o_Tx_Serial <= r_txShift[0];
              r_txShift   <= {1'b0, r_txShift[7:1]};
            end else begin
              r_bitIdx    <= 3'd0;
              o_Tx_Serial <= 1'b1;
              r_state     <= STOP;
            end
          end
        end
        STOP: begin
          if (r_clkCount < LAST_COUNT) begin
            r_clkCount <= r_clkCount + 16'd1;
          end else begin
            r_clkCount  <= 16'd0;
            o_Tx_Done   <= 1'b1;
            o_Tx_Active <= 1'b0;
            r_state     <= CLEANUP;
          end
        end
        CLEANUP: begin
          o_Tx_Done <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent TX and RX engines on one clock.
// The wrapper adds no logic of its own.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_Clock     (i_Clock),
    .i_Rst_n     (i_Rst_n),
    .i_Tx_DV     (i_Tx_DV),
    .i_Tx_Byte   (i_Tx_Byte),
    .o_Tx_Active (o_Tx_Active),
    .o_Tx_Serial (o_Tx_Serial),
    .o_Tx_Done   (o_Tx_Done)
  );

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_Clock     (i_Clock),
    .i_Rst_n     (i_Rst_n),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Rx_DV     (o_Rx_DV),
    .o_Rx_Byte   (o_Rx_Byte)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: reset, TX waveform, loopback,
// RX glitch and framing error, and mid-frame reset.
module tb_uart_transceiver;

  localparam int CPB = 100;

  logic       clock = 1'b0;
  logic       rstN = 1'b0;
  logic       txDv = 1'b0;
  logic [7:0] txByte = 8'h00;
  logic       rxDrive = 1'b1;
  logic       loopback = 1'b0;
  logic       rxSerial;
  logic       rxDv;
  logic [7:0] rxByte;
  logic       txActive;
  logic       txSerial;
  logic       txDone;

  int checks = 0;
  int errors = 0;
  int rxDvCount = 0;
  int txDoneCount = 0;
  int dvWide = 0;
  logic prevDv = 1'b0;
  logic [7:0] rxHist[$];

  assign rxSerial = loopback ? txSerial : rxDrive;

  uart_transceiver #(
    .CLKS_PER_BIT(16'(CPB))
  ) dut (
    .i_Clock     (clock),
    .i_Rst_n     (rstN),
    .i_Rx_Serial (rxSerial),
    .o_Rx_DV     (rxDv),
    .o_Rx_Byte   (rxByte),
    .i_Tx_DV     (txDv),
    .i_Tx_Byte   (txByte),
    .o_Tx_Active (txActive),
    .o_Tx_Serial (txSerial),
    .o_Tx_Done   (txDone)
  );

  always #5 clock = ~clock;

  // Record every received byte and TX completion, and catch DV pulses
  // that last longer than one cycle.
  always @(negedge clock) begin
    if (rxDv) begin
      rxDvCount++;
      rxHist.push_back(rxByte);
      if (prevDv) dvWide++;
    end
    prevDv = rxDv;
    if (txDone) txDoneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [7:0] data);
    txDv   = dv;
    txByte = data;
  endtask

  task automatic sendRxFrame(input logic [7:0] data, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rxDrive = frame[b];
      repeat (CPB) @(negedge clock);
    end
    rxDrive = 1'b1;
  endtask

  task automatic waitTxDone(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clock);
      if (txDone) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int serErr;
    int actErr;
    int doneCnt;
    int doneAt;
    int lowCnt;
    int base;
    int dvBase;
    int doneBase;
    logic expSer;
    logic [7:0] pat;
    logic [7:0] seq [3];

    // Reset held for two cycles, then released.
    rstN = 1'b0;
    repeat (2) @(negedge clock);
    rstN = 1'b1;
    @(negedge clock);
    checkOutput("reset txSerial", 32'(txSerial), 32'd1);
    checkOutput("reset txActive", 32'(txActive), 32'd0);
    checkOutput("reset txDone", 32'(txDone), 32'd0);
    checkOutput("reset rxDv", 32'(rxDv), 32'd0);
    checkOutput("reset rxByte", 32'(rxByte), 32'h00);
    lowCnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (txSerial !== 1'b1) lowCnt++;
    end
    checkOutput("idle line low cycles", 32'(lowCnt), 32'd0);

    // Single frame of 8'h06 with DV held for four cycles.
    pat = 8'h06;
    serErr = 0;
    actErr = 0;
    doneCnt = 0;
    doneAt = 0;
    applyStimulus(1'b1, pat);
    for (int n = 1; n <= 1100; n++) begin
      @(negedge clock);
      if (n == 4) applyStimulus(1'b0, 8'h00);
      if (n <= 100) expSer = 1'b0;
      else if (n <= 900) expSer = pat[(n - 101) / 100];
      else expSer = 1'b1;
      if (txSerial !== expSer) serErr++;
      if (txActive !== (n <= 1000)) actErr++;
      if (txDone === 1'b1) begin
        doneCnt++;
        doneAt = n;
      end
    end
    checkOutput("tx06 serial errors", 32'(serErr), 32'd0);
    checkOutput("tx06 active errors", 32'(actErr), 32'd0);
    checkOutput("tx06 done count", 32'(doneCnt), 32'd1);
    checkOutput("tx06 done cycle", 32'(doneAt), 32'd1001);

    // Loopback of three bytes spaced 200 ns apart.
    loopback = 1'b1;
    base = rxHist.size();
    dvBase = rxDvCount;
    seq = '{8'h06, 8'h11, 8'h9D};
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      applyStimulus(1'b1, seq[k]);
      @(negedge clock);
      applyStimulus(1'b0, 8'h00);
      waitTxDone("loopback tx done");
      repeat (20) @(negedge clock);
    end
    repeat (200) @(negedge clock);
    checkOutput("loopback dv count", 32'(rxDvCount - dvBase), 32'd3);
    checkOutput("loopback byte0", 32'(rxHist[base]), 32'h06);
    checkOutput("loopback byte1", 32'(rxHist[base + 1]), 32'h11);
    checkOutput("loopback byte2", 32'(rxHist[base + 2]), 32'h9D);
    checkOutput("loopback byte held", 32'(rxByte), 32'h9D);
    checkOutput("dv pulse width", 32'(dvWide), 32'd0);
    loopback = 1'b0;

    // Short low glitch on RX, then a valid 8'hA5 frame.
    dvBase = rxDvCount;
    rxDrive = 1'b0;
    repeat (20) @(negedge clock);
    rxDrive = 1'b1;
    repeat (150) @(negedge clock);
    checkOutput("glitch no dv", 32'(rxDvCount - dvBase), 32'd0);
    checkOutput("glitch byte held", 32'(rxByte), 32'h9D);
    sendRxFrame(8'hA5, 1'b1);
    repeat (50) @(negedge clock);
    checkOutput("A5 dv count", 32'(rxDvCount - dvBase), 32'd1);
    checkOutput("A5 byte", 32'(rxByte), 32'hA5);

    // Framing error on 8'h3C, then a valid 8'h55 frame.
    dvBase = rxDvCount;
    sendRxFrame(8'h3C, 1'b0);
    repeat (300) @(negedge clock);
    checkOutput("framing no dv", 32'(rxDvCount - dvBase), 32'd0);
    checkOutput("framing byte held", 32'(rxByte), 32'hA5);
    sendRxFrame(8'h55, 1'b1);
    repeat (50) @(negedge clock);
    checkOutput("55 dv count", 32'(rxDvCount - dvBase), 32'd1);
    checkOutput("55 byte", 32'(rxByte), 32'h55);

    // Reset in the middle of a looped-back frame, then a fresh 8'hFF.
    loopback = 1'b1;
    @(negedge clock);
    applyStimulus(1'b1, 8'h3C);
    @(negedge clock);
    applyStimulus(1'b0, 8'h00);
    repeat (400) @(negedge clock);
    checkOutput("midframe tx active", 32'(txActive), 32'd1);
    rstN = 1'b0;
    @(negedge clock);
    checkOutput("abort txSerial", 32'(txSerial), 32'd1);
    checkOutput("abort txActive", 32'(txActive), 32'd0);
    checkOutput("abort txDone", 32'(txDone), 32'd0);
    checkOutput("abort rxDv", 32'(rxDv), 32'd0);
    checkOutput("abort rxByte", 32'(rxByte), 32'h00);
    dvBase = rxDvCount;
    doneBase = txDoneCount;
    @(negedge clock);
    rstN = 1'b1;
    repeat (1200) @(negedge clock);
    checkOutput("post abort no dv", 32'(rxDvCount - dvBase), 32'd0);
    checkOutput("post abort no done", 32'(txDoneCount - doneBase), 32'd0);
    applyStimulus(1'b1, 8'hFF);
    @(negedge clock);
    applyStimulus(1'b0, 8'h00);
    waitTxDone("FF tx done");
    repeat (50) @(negedge clock);
    checkOutput("FF dv count", 32'(rxDvCount - dvBase), 32'd1);
    checkOutput("FF byte", 32'(rxByte), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
